irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller for the Spartan-3 CPU. Timer expiry pulses arrive on source 0;
//  other peripherals use the remaining sources. Each event is latched as pending and
//  gated by a mask. The highest-priority pending source is presented to the CPU core
//  with a req/ack/eoi handshake.
// PARAMETERS
//  N_SRC  4  number of interrupt sources; source 0 is the timer
//  ID_W   2  width of irq_id; must satisfy 2**ID_W >= N_SRC
// PORTS
//  clk        in   1      system clock; everything is on the rising edge
//  rst        in   1      synchronous, active-high reset
//  src_pulse  in   N_SRC  one-cycle event pulses; bit 0 is the timer expiry
//  mask_we    in   1      write strobe for the mask register
//  mask_wdata in   N_SRC  new mask value; 1 = source enabled
//  ovr_clr    in   N_SRC  per-bit clear of the sticky overrun flags
//  irq_ack    in   1      CPU accepts the request; one-cycle pulse
//  irq_eoi    in   1      CPU signals end of interrupt service; one-cycle pulse
//  irq_req    out  1      interrupt request to the CPU
//  irq_id     out  ID_W   index of the requested source
//  pending    out  N_SRC  latched pending events (status readback)
//  mask       out  N_SRC  current mask register
//  overrun    out  N_SRC  sticky flag: an event arrived while that source was already pending
//  busy       out  1      high while an interrupt is in service
// BEHAVIOUR
//  Reset values: irq_req=0, irq_id=0, pending=0, mask=0 (all sources disabled),
//   overrun=0, busy=0, FSM=IDLE.
//  Pending register, per bit i, each cycle:
//   - src_pulse[i] sets pending[i]. Set takes priority over a same-cycle ack clear.
//   - If src_pulse[i]=1 and pending[i] is already 1 (and not being cleared this cycle),
//     overrun[i] is set.
//   - ovr_clr[i] clears overrun[i]. A same-cycle set of overrun[i] wins over the clear.
//   - Events are latched regardless of the mask; the mask only gates selection.
//  mask_we=1: mask <= mask_wdata. The new value is visible to selection from the next cycle.
//  Selection: sel = lowest index i with pending[i] & mask[i]. Index 0 (timer) has highest priority.
//  FSM:
//   IDLE:    if any (pending & mask) -> REQ. On that edge, irq_id <= sel and irq_req <= 1.
//            Request latency is 1 cycle from a registered pending bit;
//            2 cycles from the src_pulse edge.
//   REQ:     irq_req=1; irq_id is held stable. Later higher-priority events
//            and mask changes do not alter irq_id or withdraw the request.
//            On irq_ack: clear pending[irq_id], irq_req <= 0, busy <= 1 -> SERVICE.
//   SERVICE: irq_req=0, busy=1. Nesting is not supported.
//            On irq_eoi: busy <= 0 -> IDLE.
//            The next request can assert at the earliest 1 cycle after returning to IDLE.
//  Inputs ignored outside their state:
//   - irq_ack in IDLE or SERVICE is ignored.
//   - irq_eoi in IDLE or REQ is ignored.
//   - Same-cycle irq_ack and irq_eoi in REQ: the ack is taken, the eoi is ignored.
//  Reset mid-operation (any state): all registers return to their reset values.
//   Pending events are lost.
//  Invalid index: if irq_id >= N_SRC cannot occur by construction. The index width is
//   checked only through the parameter rule (2**ID_W >= N_SRC).
// TESTING
//  1. mask=4'b0001; timer pulse on bit 0 -> irq_req=1 two cycles later, irq_id=0;
//     ack -> pending[0]=0, busy=1; eoi -> busy=0.
//  2. mask=4'b1111; pulses on bits 3 and 1 in the same cycle -> irq_id=1 first;
//     after ack/eoi -> irq_id=3 served next.
//  3. mask=0; pulse on bit 2 -> pending=4'b0100, irq_req stays 0;
//     write mask=4'b0100 -> irq_req=1 two cycles after the write, irq_id=2.
//  4. pending[0]=1 in REQ; second timer pulse -> overrun[0]=1;
//     ovr_clr[0] -> overrun[0]=0; pulse coinciding with ack -> pending[0] stays 1.
//  5. In REQ with irq_id=2, pulse on bit 0 -> irq_id stays 2 until ack;
//     stray ack in IDLE and stray eoi in REQ -> no state change.
//  6. rst asserted during SERVICE with pending=4'b1010 -> next cycle all outputs 0, FSM=IDLE.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source pending latch, mask gating, fixed priority (source 0 highest)
// and a req/ack/eoi handshake toward the CPU core.
module irq_ctrl #(
   parameter int N_SRC = 4,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_pulse,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   input  logic [N_SRC-1:0] ovr_clr,
   input  logic             irq_ack,
   input  logic             irq_eoi,
   output logic             irq_req,
   output logic [ID_W-1:0]  irq_id,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] mask,
   output logic [N_SRC-1:0] overrun,
   output logic             busy
);

   generate
      if ((2 ** ID_W) < N_SRC) begin : g_id_w_check
         $error("irq_ctrl: ID_W too narrow for N_SRC");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             load_id;
   logic             any_act;
   logic [ID_W-1:0]  sel;
   logic             ack_take;
   logic [N_SRC-1:0] clr_vec;
   logic [N_SRC-1:0] pending_nxt;
   logic [N_SRC-1:0] overrun_nxt;

   // Lowest enabled pending index wins; scanning downward leaves the lowest in sel.
   always_comb begin
      sel     = '0;
      any_act = |(pending & mask);
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (pending[i] && mask[i]) begin
            sel = ID_W'(i);
         end
      end
   end

   assign ack_take = (state == REQ) && irq_ack;

   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < N_SRC; i++) begin
         clr_vec[i] = ack_take && (irq_id == ID_W'(i));
      end
   end

   // A new pulse beats the ack clear; overrun only when the bit stays pending.
   assign pending_nxt = src_pulse | (pending & ~clr_vec);
   assign overrun_nxt = (src_pulse & pending & ~clr_vec) | (overrun & ~ovr_clr);

   always_comb begin
      state_nxt = state;
      load_id   = 1'b0;
      case (state)
         IDLE: begin
            if (any_act) begin
               state_nxt = REQ;
               load_id   = 1'b1;
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_nxt = SERVICE;
            end
         end
         SERVICE: begin
            if (irq_eoi) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         irq_req <= 1'b0;
         busy    <= 1'b0;
         irq_id  <= '0;
         pending <= '0;
         mask    <= '0;
         overrun <= '0;
      end else begin
         state   <= state_nxt;
         irq_req <= (state_nxt == REQ);
         busy    <= (state_nxt == SERVICE);
         if (load_id) begin
            irq_id <= sel;
         end
         pending <= pending_nxt;
         overrun <= overrun_nxt;
         if (mask_we) begin
            mask <= mask_wdata;
         end
      end
   end

endmodule
